// File: rtl/servo_pwm_monitor.sv
// servo_pwm_monitor
//   Measures an asynchronous servo PWM line in ticks of CLK_DIV clocks.
//   Reports the last high time, the rising-to-rising period, a position code
//   derived from the high time, and range/timeout flags.
//
//   state | meaning
//   IDLE  | waiting for a rising edge; partial pulses are discarded
//   HIGH  | line high, counting width and period
//   LOW   | line low, counting period; next rise publishes
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pwm_in       asynchronous servo PWM line
//   width        last measured high time, ticks
//   period       last measured period, ticks
//   pos          (width-MIN_PW)>>POS_SHIFT, 0 below MIN_PW, saturated to 255
//   valid        one-clock pulse when width/period/pos/err_range update
//   err_range    last width outside [MIN_PW, MAX_PW]
//   err_timeout  no complete pulse within MAX_PERIOD ticks, cleared by valid
module servo_pwm_monitor #(
   parameter int CLK_DIV     = 100,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_PW      = 500,
   parameter int MAX_PW      = 2500,
   parameter int MAX_PERIOD  = 25000,
   parameter int POS_SHIFT   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pwm_in,
   output logic [11:0] width,
   output logic [14:0] period,
   output logic [7:0]  pos,
   output logic        valid,
   output logic        err_range,
   output logic        err_timeout
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [11:0]   MIN_W      = 12'(MIN_PW);
   localparam logic [11:0]   MAX_W      = 12'(MAX_PW);
   localparam logic [11:0]   W_SAT      = 12'hFFF;
   localparam logic [14:0]   PER_LAST   = 15'(MAX_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d;
   logic                   rise_q;
   logic                   fall_q;
   logic [PW-1:0]          presc;
   logic                   tick;

   state_t      state_q, state_d;
   logic [11:0] width_cnt, width_d;
   logic [14:0] per_cnt, per_d, per_tick;
   logic        publish;
   logic        timeout;
   logic [11:0] pos_diff;
   logic [7:0]  pos_calc;
   logic        range_bad;

   // Edges are registered so both edges see the same fixed pipeline delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         s_d    <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_d    <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~s_d;
         fall_q <= ~sync_q[SYNC_STAGES-1] & s_d;
      end
   end

   // Clearing on the rise aligns ticks to the period start, so counts are floors.
   assign tick = (presc == PRESC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (rise_q || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      width_d  = width_cnt;
      per_d    = per_cnt;
      publish  = 1'b0;
      // Includes a tick landing on the closing rise so period = floor(cycles/CLK_DIV).
      per_tick = per_cnt + {14'd0, tick};
      timeout  = tick && (per_cnt == PER_LAST);
      if (timeout) begin
         // A rise coinciding with the timeout starts a fresh measurement.
         width_d = '0;
         per_d   = '0;
         state_d = rise_q ? HIGH : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise_q) begin
                  state_d = HIGH;
                  width_d = '0;
                  per_d   = '0;
               end else begin
                  per_d = per_tick;
               end
            end
            HIGH: begin
               per_d = per_tick;
               if (tick && (width_cnt != W_SAT)) width_d = width_cnt + 12'd1;
               if (fall_q) state_d = LOW;
            end
            LOW: begin
               if (rise_q) begin
                  publish = 1'b1;
                  state_d = HIGH;
                  width_d = '0;
                  per_d   = '0;
               end else begin
                  per_d = per_tick;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      range_bad = (width_cnt < MIN_W) || (width_cnt > MAX_W);
      pos_diff  = (width_cnt - MIN_W) >> POS_SHIFT;
      if (width_cnt < MIN_W) begin
         pos_calc = 8'd0;
      end else if (pos_diff > 12'd255) begin
         pos_calc = 8'hFF;
      end else begin
         pos_calc = pos_diff[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         width_cnt   <= '0;
         per_cnt     <= '0;
         width       <= '0;
         period      <= '0;
         pos         <= '0;
         valid       <= 1'b0;
         err_range   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state_q   <= state_d;
         width_cnt <= width_d;
         per_cnt   <= per_d;
         valid     <= publish;
         if (publish) begin
            width       <= width_cnt;
            period      <= per_tick;
            pos         <= pos_calc;
            err_range   <= range_bad;
            err_timeout <= 1'b0;
         end else if (timeout) begin
            err_timeout <= 1'b1;
         end
      end
   end

endmodule
